ex_muldiv: RTL and testbench
============================

# ex_muldiv

Multi-cycle multiply/divide unit in the execute stage of the dual-issue pipeline. It consumes the master-slot operands and ALU opcode registered by the ID/EX stage. It computes 64-bit {hi,lo} results for MULT/MULTU/DIV/DIVU and holds EX with a stall while busy. Results go to the HI/LO write path when the instruction leaves EX. Only the master slot issues mul/div.

## Interface
Parameters:
- DIV_ITER, 32, number of radix-2 divide iterations. Must equal the operand width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  EX master instruction is a mul/div opcode and is valid (not bubbled)
- aluop  in  8  EX master ALU opcode
- a  in  32  rs value (dividend / multiplicand)
- b  in  32  rt value (divisor / multiplier)
- hilo_in  in  64  current {hi,lo}, forwarded. Used only for accumulate ops.
- flush  in  1  exception/mispredict flush of EX. Cancels any operation.
- ena  in  1  EX→MEM register advance this cycle
- stall  out  1  hold EX and all upstream stages
- result_valid  out  1  result register holds the finished result
- result  out  64  {hi,lo}. For divide: hi = remainder, lo = quotient.

## Operation
- States: IDLE, MUL, ACC (present only with the configured feature), DIV, FIX, DONE.
- IDLE: when start=1 and flush=0:
  - capture a, b, aluop and hilo_in.
  - Mul ops go to MUL; div ops go to DIV.
  - Non-mul/div aluop with start=1: stay in IDLE, stall=0.
- MUL: operands are split into 16-bit halves. The four partial products are registered with sign-extended (signed) or zero-extended (unsigned) 33-bit handling. The sum goes to the result, then DONE (or ACC for accumulate ops).
- DIV: restoring radix-2 on absolute values (signed ops) or raw values (unsigned ops). One quotient bit per cycle for DIV_ITER cycles, then FIX.
- FIX: apply signs. Quotient is negated if sign(a)^sign(b). Remainder takes the sign of a. Then DONE.
- Divide by zero: quotient 0xFFFFFFFF (pre-fix), remainder = |a|. Sign fix is applied as normal. No exception.
- 0x80000000 / 0xFFFFFFFF (signed): quotient 0x80000000, remainder 0.
- DONE:
  - result_valid=1 and result is stable.
  - start is ignored (it is the same instruction still in EX).
  - Leave to IDLE when ena=1.
- flush=1 in any state: next state IDLE and result_valid=0. flush has priority over start and ena.

## Timing
- Reset values: state IDLE, stall 0, result_valid 0, result 0, all internal registers 0.
- stall = (IDLE & start & muldiv op & ~flush) | MUL | ACC | DIV | FIX. stall is combinational from start in IDLE only.
- Multiply, start accepted at cycle T:
  - MUL at T+1, DONE at T+2.
  - stall high during T and T+1.
- Divide, start accepted at T:
  - DIV at T+1..T+32, FIX at T+33, DONE at T+34.
  - stall high during T..T+33.
- DONE with ena=1 at cycle D: IDLE at D+1. A new start at D+1 is accepted, so back-to-back ops lose no extra cycle.
- Flush at cycle F: IDLE at F+1, stall=0 at F+1. A start at F+1 is accepted.

## Configuration
- MULDIV_MADD_EN defined:
  - MADD/MADDU/MSUB/MSUBU are supported.
  - After MUL, the ACC state computes hilo_in ± product (64-bit wrap), then DONE.
  - Multiply-accumulate latency is 3 cycles; stall is high T..T+2.
- Undefined: the ACC state and hilo_in logic are removed. Accumulate opcodes are treated as non-mul/div (stall=0). hilo_in is left unconnected.

## Structure
- Shared package holds:
  - the aluop constants (MULT, MULTU, DIV, DIVU, and MADD/MADDU/MSUB/MSUBU),
  - the muldiv_state_t enum,
  - the 64-bit hilo_t typedef.
- One sub-module, div_radix2: the iterative unsigned divider core (start/busy/done, quotient/remainder). ex_muldiv owns sign handling, multiply and the FSM.

## Test plan
- MULT a=0xFFFFFFFE, b=3 -> result_valid at T+2, result 0xFFFFFFFF_FFFFFFFA. MULTU with the same operands -> 0x00000002_FFFFFFFA.
- DIV a=0xFFFFFFF9 (-7), b=2 -> stall high T..T+33; at T+34 hi=0xFFFFFFFF, lo=0xFFFFFFFD.
- DIVU a=5, b=0 -> hi=0x00000005, lo=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF -> hi=0, lo=0x80000000.
- DIV start, flush at T+10 -> IDLE at T+11, stall 0, result_valid never asserted. MULT started at T+11 completes at T+13.
- DONE held with ena=0 for 3 cycles while start stays high -> result_valid and result stable, no restart. ena=1 -> IDLE next cycle.
- With MULDIV_MADD_EN: MADD a=2, b=3, hilo_in=0x00000000_FFFFFFFF -> result 0x00000001_00000005 at T+3.

Source files
------------

// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg: shared definitions for the EX-stage multiply/divide unit.
//   - ALU opcode constants for the mul/div family
//   - muldiv_state_t FSM encoding
//   - hilo_t 64-bit {hi,lo} type
//   - opcode classification helpers
// Build option: MULDIV_MADD_EN enables the multiply-accumulate opcodes
// (MADD/MADDU/MSUB/MSUBU). Without it those opcodes classify as non-mul/div.
package ex_muldiv_pkg;

    localparam logic [7:0] ALU_MULT  = 8'h18;
    localparam logic [7:0] ALU_MULTU = 8'h19;
    localparam logic [7:0] ALU_DIV   = 8'h1a;
    localparam logic [7:0] ALU_DIVU  = 8'h1b;
    localparam logic [7:0] ALU_MADD  = 8'h1c;
    localparam logic [7:0] ALU_MADDU = 8'h1d;
    localparam logic [7:0] ALU_MSUB  = 8'h1e;
    localparam logic [7:0] ALU_MSUBU = 8'h1f;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
`ifdef MULDIV_MADD_EN
        S_ACC  = 3'd2,
`endif
        S_DIV  = 3'd3,
        S_FIX  = 3'd4,
        S_DONE = 3'd5
    } muldiv_state_t;

    typedef logic [63:0] hilo_t;

    function automatic logic is_acc_op(input logic [7:0] op);
`ifdef MULDIV_MADD_EN
        return (op == ALU_MADD) || (op == ALU_MADDU) ||
               (op == ALU_MSUB) || (op == ALU_MSUBU);
`else
        return (op == 8'hff) && 1'b0;
`endif
    endfunction

    function automatic logic is_sub_op(input logic [7:0] op);
        return (op == ALU_MSUB) || (op == ALU_MSUBU);
    endfunction

    // Accumulate ops ride the multiplier, so they count as mul ops when enabled.
    function automatic logic is_mul_op(input logic [7:0] op);
        return (op == ALU_MULT) || (op == ALU_MULTU) || is_acc_op(op);
    endfunction

    function automatic logic is_div_op(input logic [7:0] op);
        return (op == ALU_DIV) || (op == ALU_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [7:0] op);
        return (op == ALU_MULT) || (op == ALU_DIV) ||
               (op == ALU_MADD) || (op == ALU_MSUB);
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: EX-stage hookup between the pipeline and the mul/div unit.
//   master (pipeline): start, aluop, a, b, hilo_in, flush, ena  -> unit
//   slave  (unit)    : stall, result_valid, result             -> pipeline
// hilo_in is only consumed when MULDIV_MADD_EN is defined.
interface ex_muldiv_if;
    import ex_muldiv_pkg::*;

    logic        start;
    logic [7:0]  aluop;
    logic [31:0] a;
    logic [31:0] b;
    hilo_t       hilo_in;
    logic        flush;
    logic        ena;
    logic        stall;
    logic        result_valid;
    hilo_t       result;

    modport master (
        output start, aluop, a, b, hilo_in, flush, ena,
        input  stall, result_valid, result
    );

    modport slave (
        input  start, aluop, a, b, hilo_in, flush, ena,
        output stall, result_valid, result
    );

endinterface

// File: rtl/ex_muldiv_div_radix2.sv
// ex_muldiv_div_radix2: iterative unsigned restoring divider (div_radix2 core).
//   clk, rst     : clock, synchronous active-high reset
//   start        : load dividend/divisor, begin DIV_ITER iterations
//   abort        : drop any division in progress
//   busy         : iterations remain
//   done         : final iteration happens this cycle; quotient/remainder
//                  are complete from the next cycle on
//   quotient/remainder : results, held until the next start
// Divisor 0 naturally yields quotient all-ones and remainder = dividend.
module ex_muldiv_div_radix2 #(
    parameter int DIV_ITER = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [DIV_ITER-1:0] dividend,
    input  logic [DIV_ITER-1:0] divisor,
    output logic                busy,
    output logic                done,
    output logic [DIV_ITER-1:0] quotient,
    output logic [DIV_ITER-1:0] remainder
);

    localparam int W  = DIV_ITER;
    localparam int CW = $clog2(DIV_ITER + 1);

    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  dvs_q, dvs_d;
    logic [W:0]    shifted;
    logic [W:0]    diff;

    assign busy      = (count_q != '0);
    assign done      = (count_q == CW'(1));
    assign quotient  = quo_q;
    assign remainder = rem_q;

    always_comb begin
        count_d = count_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        // Dividend bits shift out of the quotient register into the remainder.
        shifted = {rem_q, quo_q[W-1]};
        diff    = shifted - {1'b0, dvs_q};
        if (abort) begin
            count_d = '0;
        end else if (start) begin
            count_d = CW'(DIV_ITER);
            quo_d   = dividend;
            rem_d   = '0;
            dvs_d   = divisor;
        end else if (busy) begin
            count_d = count_q - CW'(1);
            if (!diff[W]) begin
                rem_d = diff[W-1:0];
                quo_d = {quo_q[W-2:0], 1'b1};
            end else begin
                rem_d = shifted[W-1:0];
                quo_d = {quo_q[W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
        end else begin
            count_q <= count_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: multi-cycle MULT/MULTU/DIV/DIVU unit for the EX master slot.
//   clk, rst : clock, synchronous active-high reset
//   bus      : ex_muldiv_if.slave (start/aluop/a/b/hilo_in/flush/ena in,
//              stall/result_valid/result out)
// Result is {hi,lo}; for divides hi = remainder, lo = quotient.
// Build option: MULDIV_MADD_EN adds the ACC state and MADD/MADDU/MSUB/MSUBU.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting; accepts a mul/div start (stall combinational)
// MUL    | sum the registered 17x17 partial products into result
// ACC    | result = hilo_in +/- product (MULDIV_MADD_EN only)
// DIV    | divider core iterating, one quotient bit per cycle
// FIX    | apply quotient/remainder signs
// DONE   | result_valid; hold until ena moves the instruction on
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    ex_muldiv_if.slave  bus
);

    muldiv_state_t state_q, state_d;

    logic        op_mul, op_div, op_signed, accept, div_start;
    logic        sx_a, sx_b;
    logic [32:0] a_hi, a_lo, b_hi, b_lo;
    logic [31:0] abs_a, abs_b;
    logic [32:0] pp_hh_q, pp_hh_d, pp_hl_q, pp_hl_d;
    logic [32:0] pp_lh_q, pp_lh_d, pp_ll_q, pp_ll_d;
    logic        quo_neg_q, quo_neg_d, rem_neg_q, rem_neg_d;
    hilo_t       result_q, result_d;
    hilo_t       mul_sum;
    logic [31:0] quo_fix, rem_fix;
    logic        div_busy, div_done;
    logic [31:0] div_quo, div_rem;
    logic        stall, result_valid;
`ifdef MULDIV_MADD_EN
    logic        acc_q, acc_d, sub_q, sub_d;
    hilo_t       hilo_q, hilo_d;
`endif

    assign op_mul    = is_mul_op(bus.aluop);
    assign op_div    = is_div_op(bus.aluop);
    assign op_signed = is_signed_op(bus.aluop);
    assign accept    = (state_q == S_IDLE) && bus.start && !bus.flush && (op_mul || op_div);
    assign div_start = accept && op_div;

    // Split into 16-bit halves widened to 33 bits: upper half carries the
    // operand sign for signed ops, lower half is always unsigned. Every
    // 33x33 product then fits its 33-bit register exactly (mod 2^33).
    assign sx_a = op_signed & bus.a[31];
    assign sx_b = op_signed & bus.b[31];
    assign a_hi = {{17{sx_a}}, bus.a[31:16]};
    assign a_lo = {17'b0, bus.a[15:0]};
    assign b_hi = {{17{sx_b}}, bus.b[31:16]};
    assign b_lo = {17'b0, bus.b[15:0]};

    assign abs_a = sx_a ? (~bus.a + 32'd1) : bus.a;
    assign abs_b = sx_b ? (~bus.b + 32'd1) : bus.b;

    assign mul_sum = ({{31{pp_hh_q[32]}}, pp_hh_q} << 32)
                   + (({{31{pp_hl_q[32]}}, pp_hl_q} + {{31{pp_lh_q[32]}}, pp_lh_q}) << 16)
                   + {{31{pp_ll_q[32]}}, pp_ll_q};

    assign quo_fix = quo_neg_q ? (~div_quo + 32'd1) : div_quo;
    assign rem_fix = rem_neg_q ? (~div_rem + 32'd1) : div_rem;

    ex_muldiv_div_radix2 #(
        .DIV_ITER (DIV_ITER)
    ) u_div_radix2 (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .abort     (bus.flush),
        .dividend  (abs_a),
        .divisor   (abs_b),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (accept) state_d = op_div ? S_DIV : S_MUL;
`ifdef MULDIV_MADD_EN
                S_MUL:   state_d = acc_q ? S_ACC : S_DONE;
                S_ACC:   state_d = S_DONE;
`else
                S_MUL:   state_d = S_DONE;
`endif
                // !div_busy guards against waiting on a core that is not running.
                S_DIV:   if (div_done || !div_busy) state_d = S_FIX;
                S_FIX:   state_d = S_DONE;
                S_DONE:  if (bus.ena) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        stall        = 1'b0;
        result_valid = 1'b0;
        case (state_q)
            S_IDLE:  stall = accept;
            S_MUL,
`ifdef MULDIV_MADD_EN
            S_ACC,
`endif
            S_DIV,
            S_FIX:   stall = 1'b1;
            S_DONE:  result_valid = 1'b1;
            default: stall = 1'b0;
        endcase
    end

    assign bus.stall        = stall;
    assign bus.result_valid = result_valid;
    assign bus.result       = result_q;

    // Datapath
    always_comb begin
        pp_hh_d   = pp_hh_q;
        pp_hl_d   = pp_hl_q;
        pp_lh_d   = pp_lh_q;
        pp_ll_d   = pp_ll_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        result_d  = result_q;
`ifdef MULDIV_MADD_EN
        acc_d     = acc_q;
        sub_d     = sub_q;
        hilo_d    = hilo_q;
`endif
        if (accept) begin
            pp_hh_d   = a_hi * b_hi;
            pp_hl_d   = a_hi * b_lo;
            pp_lh_d   = a_lo * b_hi;
            pp_ll_d   = a_lo * b_lo;
            quo_neg_d = sx_a ^ sx_b;
            rem_neg_d = sx_a;
`ifdef MULDIV_MADD_EN
            acc_d     = is_acc_op(bus.aluop);
            sub_d     = is_sub_op(bus.aluop);
            hilo_d    = bus.hilo_in;
`endif
        end
        case (state_q)
            S_MUL:   result_d = mul_sum;
`ifdef MULDIV_MADD_EN
            S_ACC:   result_d = sub_q ? (hilo_q - result_q) : (hilo_q + result_q);
`endif
            S_FIX:   result_d = {rem_fix, quo_fix};
            default: result_d = result_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pp_hh_q   <= '0;
            pp_hl_q   <= '0;
            pp_lh_q   <= '0;
            pp_ll_q   <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            result_q  <= '0;
`ifdef MULDIV_MADD_EN
            acc_q     <= 1'b0;
            sub_q     <= 1'b0;
            hilo_q    <= '0;
`endif
        end else begin
            pp_hh_q   <= pp_hh_d;
            pp_hl_q   <= pp_hl_d;
            pp_lh_q   <= pp_lh_d;
            pp_ll_q   <= pp_ll_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            result_q  <= result_d;
`ifdef MULDIV_MADD_EN
            acc_q     <= acc_d;
            sub_q     <= sub_d;
            hilo_q    <= hilo_d;
`endif
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_muldiv_if bus ();

    ex_muldiv #(.DIV_ITER(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int    checks = 0;
    int    errors = 0;
    hilo_t exp_q[$];
    string tag_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every cycle a result is presented it must match the oldest
    // expected entry; the entry retires when the pipeline takes it (ena).
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.result_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got %h expected no result", bus.result);
                end else begin
                    chk({"result_", tag_q[0]}, bus.result, exp_q[0]);
                    if (bus.ena) begin
                        void'(exp_q.pop_front());
                        void'(tag_q.pop_front());
                    end
                end
            end
        end
    end

    // Issue one op, check stall for lat cycles, hold DONE for hold cycles
    // with start still high, then retire with ena.
    task automatic do_op(input logic [7:0] op, input logic [31:0] av, input logic [31:0] bv,
                         input hilo_t hv, input hilo_t exp, input int lat, input int hold,
                         input string nm);
        exp_q.push_back(exp);
        tag_q.push_back(nm);
        bus.start   = 1'b1;
        bus.aluop   = op;
        bus.a       = av;
        bus.b       = bv;
        bus.hilo_in = hv;
        bus.ena     = 1'b0;
        for (int c = 0; c < lat; c++) begin
            @(negedge clk);
            chk({nm, "_stall_busy"}, {63'b0, bus.stall}, 64'd1);
            chk({nm, "_valid_busy"}, {63'b0, bus.result_valid}, 64'd0);
            tick();
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({nm, "_valid_hold"}, {63'b0, bus.result_valid}, 64'd1);
            chk({nm, "_stall_hold"}, {63'b0, bus.stall}, 64'd0);
            tick();
        end
        bus.ena   = 1'b1;
        bus.start = 1'b0;
        @(negedge clk);
        chk({nm, "_valid_done"}, {63'b0, bus.result_valid}, 64'd1);
        tick();
        bus.ena = 1'b0;
        @(negedge clk);
        chk({nm, "_valid_idle"}, {63'b0, bus.result_valid}, 64'd0);
        chk({nm, "_stall_idle"}, {63'b0, bus.stall}, 64'd0);
        tick();
    endtask

    initial begin
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.aluop   = 8'h00;
        bus.a       = '0;
        bus.b       = '0;
        bus.hilo_in = '0;
        bus.flush   = 1'b0;
        bus.ena     = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("reset_stall", {63'b0, bus.stall}, 64'd0);
        chk("reset_valid", {63'b0, bus.result_valid}, 64'd0);
        chk("reset_result", bus.result, 64'd0);
        rst = 1'b0;
        tick();

        // Non-mul/div opcode with start: no stall, no result
        bus.start = 1'b1;
        bus.aluop = 8'h20;
        bus.a     = 32'd9;
        bus.b     = 32'd4;
        @(negedge clk);
        chk("nonop_stall", {63'b0, bus.stall}, 64'd0);
        tick();
        @(negedge clk);
        chk("nonop_stall2", {63'b0, bus.stall}, 64'd0);
        chk("nonop_valid", {63'b0, bus.result_valid}, 64'd0);
        bus.start = 1'b0;
        tick();

        // Multiplies
        do_op(ALU_MULT,  32'hFFFFFFFE, 32'd3,        '0, 64'hFFFFFFFF_FFFFFFFA, 2, 0, "mult_neg");
        do_op(ALU_MULTU, 32'hFFFFFFFE, 32'd3,        '0, 64'h00000002_FFFFFFFA, 2, 0, "multu");
        do_op(ALU_MULT,  32'h80000000, 32'h80000000, '0, 64'h40000000_00000000, 2, 0, "mult_min");
        do_op(ALU_MULT,  32'd7,        32'hFFFFFFFF, '0, 64'hFFFFFFFF_FFFFFFF9, 2, 0, "mult_m1");
        do_op(ALU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, '0, 64'hFFFFFFFE_00000001, 2, 0, "multu_max");
        do_op(ALU_MULT,  32'h12345678, 32'h10,       '0, 64'h00000001_23456780, 2, 3, "mult_hold");

        // Divides
        do_op(ALU_DIV,   32'hFFFFFFF9, 32'd2,        '0, 64'hFFFFFFFF_FFFFFFFD, 34, 0, "div_neg7");
        do_op(ALU_DIVU,  32'd5,        32'd0,        '0, 64'h00000005_FFFFFFFF, 34, 0, "divu_zero");
        do_op(ALU_DIV,   32'h80000000, 32'hFFFFFFFF, '0, 64'h00000000_80000000, 34, 0, "div_ovf");
        do_op(ALU_DIVU,  32'd100,      32'd7,        '0, 64'h00000002_0000000E, 34, 0, "divu_100_7");
        do_op(ALU_DIV,   32'd7,        32'hFFFFFFFE, '0, 64'h00000001_FFFFFFFD, 34, 2, "div_7_m2");
        do_op(ALU_DIVU,  32'hFFFFFFFF, 32'h10,       '0, 64'h0000000F_0FFFFFFF, 34, 0, "divu_max");

        // Flush in the middle of a divide, then a multiply right behind it
        bus.start = 1'b1;
        bus.aluop = ALU_DIV;
        bus.a     = 32'd100;
        bus.b     = 32'd7;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("flush_div_stall", {63'b0, bus.stall}, 64'd1);
            chk("flush_div_valid", {63'b0, bus.result_valid}, 64'd0);
            tick();
        end
        bus.flush = 1'b1;
        @(negedge clk);
        chk("flush_cycle_stall", {63'b0, bus.stall}, 64'd1);
        tick();
        bus.flush = 1'b0;
        do_op(ALU_MULT, 32'hFFFFFFFE, 32'd3, '0, 64'hFFFFFFFF_FFFFFFFA, 2, 0, "mult_after_flush");

`ifdef MULDIV_MADD_EN
        do_op(ALU_MADD,  32'd2,        32'd3, 64'h00000000_FFFFFFFF, 64'h00000001_00000005, 3, 0, "madd");
        do_op(ALU_MSUBU, 32'd2,        32'd3, 64'h00000000_0000000A, 64'h00000000_00000004, 3, 0, "msubu");
        do_op(ALU_MSUB,  32'hFFFFFFFF, 32'd5, 64'h00000000_00000000, 64'h00000000_00000005, 3, 0, "msub");
`else
        bus.start   = 1'b1;
        bus.aluop   = ALU_MADD;
        bus.a       = 32'd2;
        bus.b       = 32'd3;
        bus.hilo_in = 64'h00000000_FFFFFFFF;
        @(negedge clk);
        chk("madd_off_stall", {63'b0, bus.stall}, 64'd0);
        tick();
        @(negedge clk);
        chk("madd_off_stall2", {63'b0, bus.stall}, 64'd0);
        chk("madd_off_valid", {63'b0, bus.result_valid}, 64'd0);
        bus.start = 1'b0;
        tick();
`endif

        repeat (3) tick();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
